// File: rtl/rc_osc_freq_counter.sv
`default_nettype none
// ============================================================================
// Module      : rc_osc_freq_counter
// Description : Multi-channel frequency counter for the on-chip RC oscillators.
//               The selected oscillator is synchronised into clk, and its rising
//               edges are counted over a programmable gate window of clk cycles.
//               Supports single-shot and continuous (back-to-back) operation.
// Ports       : clk, rst_n              clock / async active-low reset
//               ena                     block enable, low aborts to IDLE
//               osc_in[NCH]             raw oscillator inputs (async to clk)
//               ch_sel, gate_len        channel / window, latched at start
//               mode_cont, start        continuous mode / one-cycle request
//               busy                    high whenever not IDLE
//               result, result_ch,      last completed measurement
//               result_ovf, result_vld  saturation flag / one-cycle update pulse
// Revision    : 1.0 - initial release
// ============================================================================
module rc_osc_freq_counter #(
    parameter int NCH    = 4,
    parameter int CNT_W  = 16,
    parameter int GATE_W = 16,
    localparam int CH_W  = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NCH-1:0]    osc_in,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              mode_cont,
    input  logic              start,
    output logic              busy,
    output logic [CNT_W-1:0]  result,
    output logic [CH_W-1:0]   result_ch,
    output logic              result_ovf,
    output logic              result_vld
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_GATE   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [CH_W:0]     c_NCH         = (CH_W+1)'(NCH);
    localparam logic [CNT_W-1:0]  c_CNT_MAX     = '1;
    localparam logic [GATE_W-1:0] c_SETTLE_LAST = GATE_W'(2);

    state_t              r_state;
    logic                r_busy;
    logic [CH_W-1:0]     r_ch;
    logic [GATE_W-1:0]   r_gate;
    logic [GATE_W-1:0]   r_timer;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ovf;
    logic [CNT_W-1:0]    r_result;
    logic [CH_W-1:0]     r_result_ch;
    logic                r_result_ovf;
    logic                r_result_vld;
    logic                r_s1, r_s2, r_s3;

    logic                w_osc;
    logic                w_rise;
    logic                w_cnt_sat;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_ovf_nxt;
    logic [CH_W-1:0]     w_ch_eff;
    logic [GATE_W-1:0]   w_gate_eff;

    // Out-of-range channel numbers fall back to channel 0; a zero gate is one cycle.
    assign w_ch_eff   = ({1'b0, ch_sel} < c_NCH) ? ch_sel : '0;
    assign w_gate_eff = (gate_len == '0) ? GATE_W'(1) : gate_len;

    assign w_osc      = osc_in[r_ch];
    assign w_rise     = r_s2 & ~r_s3;
    assign w_cnt_sat  = (r_cnt == c_CNT_MAX);
    assign w_cnt_nxt  = (w_rise && !w_cnt_sat) ? r_cnt + CNT_W'(1) : r_cnt;
    assign w_ovf_nxt  = r_ovf | (w_rise & w_cnt_sat);

    // Synchroniser plus edge-detect flop. It is flushed in IDLE and DONE so each
    // window starts empty; the three SETTLE cycles then refill all three flops
    // from the newly latched channel, so the first GATE cycle sees real history
    // and no stale edge can be counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else if (r_state == S_IDLE || r_state == S_DONE) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= w_osc;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Measurement FSM. The result registers and the valid pulse are loaded on
    // the GATE->DONE edge so result_vld is high exactly during the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_ch         <= '0;
            r_gate       <= '0;
            r_timer      <= '0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
            r_result     <= '0;
            r_result_ch  <= '0;
            r_result_ovf <= 1'b0;
            r_result_vld <= 1'b0;
        end else begin
            r_result_vld <= 1'b0;
            if (!ena) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_state <= S_SETTLE;
                            r_busy  <= 1'b1;
                            r_ch    <= w_ch_eff;
                            r_gate  <= w_gate_eff;
                            r_timer <= c_SETTLE_LAST;
                            r_cnt   <= '0;
                            r_ovf   <= 1'b0;
                        end
                    end
                    S_SETTLE: begin
                        if (r_timer == '0) begin
                            r_state <= S_GATE;
                            r_timer <= r_gate - GATE_W'(1);
                        end else begin
                            r_timer <= r_timer - GATE_W'(1);
                        end
                    end
                    S_GATE: begin
                        r_cnt <= w_cnt_nxt;
                        r_ovf <= w_ovf_nxt;
                        if (r_timer == '0) begin
                            r_state      <= S_DONE;
                            r_result     <= w_cnt_nxt;
                            r_result_ch  <= r_ch;
                            r_result_ovf <= w_ovf_nxt;
                            r_result_vld <= 1'b1;
                        end else begin
                            r_timer <= r_timer - GATE_W'(1);
                        end
                    end
                    S_DONE: begin
                        if (mode_cont) begin
                            r_state <= S_SETTLE;
                            r_ch    <= w_ch_eff;
                            r_gate  <= w_gate_eff;
                            r_timer <= c_SETTLE_LAST;
                            r_cnt   <= '0;
                            r_ovf   <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy       = r_busy;
    assign result     = r_result;
    assign result_ch  = r_result_ch;
    assign result_ovf = r_result_ovf;
    assign result_vld = r_result_vld;

endmodule
`default_nettype wire

// File: tb/tb_rc_osc_freq_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rc_osc_freq_counter
// Description : Directed self-checking bench for rc_osc_freq_counter. A second
//               instance with a 4-bit counter exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rc_osc_freq_counter;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [3:0]  osc_in;
    logic [1:0]  ch_sel;
    logic [15:0] gate_len;
    logic        mode_cont;
    logic        start;
    logic        start4;

    logic        busy;
    logic [15:0] result;
    logic [1:0]  result_ch;
    logic        result_ovf;
    logic        result_vld;

    logic        busy4;
    logic [3:0]  result4;
    logic [1:0]  result_ch4;
    logic        result_ovf4;
    logic        result_vld4;

    int n_checks = 0;
    int n_errors = 0;

    // Oscillator periods in clk cycles; 0 holds the channel low.
    int per [4] = '{0, 0, 0, 0};
    int ph  [4] = '{0, 0, 0, 0};

    rc_osc_freq_counter #(.NCH(4), .CNT_W(16), .GATE_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .osc_in     (osc_in),
        .ch_sel     (ch_sel),
        .gate_len   (gate_len),
        .mode_cont  (mode_cont),
        .start      (start),
        .busy       (busy),
        .result     (result),
        .result_ch  (result_ch),
        .result_ovf (result_ovf),
        .result_vld (result_vld)
    );

    rc_osc_freq_counter #(.NCH(4), .CNT_W(4), .GATE_W(16)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .osc_in     (osc_in),
        .ch_sel     (ch_sel),
        .gate_len   (gate_len),
        .mode_cont  (mode_cont),
        .start      (start4),
        .busy       (busy4),
        .result     (result4),
        .result_ch  (result_ch4),
        .result_ovf (result_ovf4),
        .result_vld (result_vld4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oscillators change 3 ns before each rising clk edge, never on it.
    initial begin
        osc_in = '0;
        #2;
        forever begin
            for (int c = 0; c < 4; c++) begin
                if (per[c] > 0) begin
                    ph[c]     = (ph[c] + 1) % per[c];
                    osc_in[c] = (ph[c] < per[c] / 2);
                end else begin
                    ph[c]     = 0;
                    osc_in[c] = 1'b0;
                end
            end
            #10;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until a result_vld is seen or n reaches limit. n counts cycles
    // since start was raised; start pulses are dropped after the first edge.
    task automatic wait_vld(input bit use4, input int limit, inout int n, output bit seen);
        seen = 1'b0;
        while (!seen && n < limit) begin
            tick();
            n++;
            start  = 1'b0;
            start4 = 1'b0;
            seen   = use4 ? result_vld4 : result_vld;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; ch_sel = '0; gate_len = '0;
        mode_cont = 1'b0; start = 1'b0; start4 = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({busy, result, result_ch, result_ovf, result_vld} !== 21'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got busy=%b res=%0d ch=%0d ovf=%b vld=%b, want all 0",
                     busy, result, result_ch, result_ovf, result_vld);
        end
        rst_n = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (busy !== 1'b0 || result_vld !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: got busy=%b vld=%b, want 0 0", busy, result_vld);
        end
    endtask

    task automatic test_single_shot();
        int n; bit seen;
        per[1] = 10; ch_sel = 2'd1; gate_len = 16'd100; mode_cont = 1'b0;
        start = 1'b1; n = 0;
        wait_vld(1'b0, 1, n, seen);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++; $display("FAIL ss_busy: got %b want 1", busy);
        end
        wait_vld(1'b0, 200, n, seen);
        n_checks++;
        if (!seen || n != 104) begin
            n_errors++; $display("FAIL ss_latency: got seen=%b n=%0d want n=104", seen, n);
        end
        n_checks++;
        if (result !== 16'd10 || result_ch !== 2'd1 || result_ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL ss_result: got %0d ch=%0d ovf=%b want 10 ch=1 ovf=0", result, result_ch, result_ovf);
        end
        tick();
        n_checks++;
        if (result_vld !== 1'b0 || busy !== 1'b0 || result !== 16'd10) begin
            n_errors++;
            $display("FAIL ss_after: got vld=%b busy=%b res=%0d want 0 0 10", result_vld, busy, result);
        end
    endtask

    task automatic test_saturate();
        int n; bit seen;
        per[0] = 2; ch_sel = 2'd0; gate_len = 16'd40;
        start4 = 1'b1; n = 0;
        wait_vld(1'b1, 100, n, seen);
        n_checks++;
        if (!seen || n != 44) begin
            n_errors++; $display("FAIL sat_latency: got seen=%b n=%0d want n=44", seen, n);
        end
        n_checks++;
        if (result4 !== 4'd15 || result_ovf4 !== 1'b1 || result_ch4 !== 2'd0) begin
            n_errors++;
            $display("FAIL sat_result: got %0d ovf=%b ch=%0d want 15 ovf=1 ch=0", result4, result_ovf4, result_ch4);
        end
        n_checks++;
        if (busy !== 1'b0 || result !== 16'd10) begin
            n_errors++; $display("FAIL sat_other_idle: got busy=%b res=%0d want 0 10", busy, result);
        end
    endtask

    task automatic test_continuous();
        int n; bit seen;
        per[2] = 4; per[3] = 5; ch_sel = 2'd2; gate_len = 16'd20; mode_cont = 1'b1;
        start = 1'b1; n = 0;
        wait_vld(1'b0, 60, n, seen);
        n_checks++;
        if (!seen || n != 24 || result !== 16'd5 || result_ch !== 2'd2) begin
            n_errors++;
            $display("FAIL cont_first: got seen=%b n=%0d res=%0d ch=%0d want n=24 5 ch=2", seen, n, result, result_ch);
        end
        // Channel change lands in GATE of the second window.
        n = 0;
        wait_vld(1'b0, 10, n, seen);
        ch_sel = 2'd3;
        n_checks++;
        if (seen || result_vld !== 1'b0) begin
            n_errors++; $display("FAIL cont_no_consec: got vld early at n=%0d want none", n);
        end
        wait_vld(1'b0, 60, n, seen);
        n_checks++;
        if (!seen || n != 24 || result !== 16'd5 || result_ch !== 2'd2) begin
            n_errors++;
            $display("FAIL cont_second: got seen=%b n=%0d res=%0d ch=%0d want n=24 5 ch=2", seen, n, result, result_ch);
        end
        n = 0;
        wait_vld(1'b0, 60, n, seen);
        n_checks++;
        if (!seen || n != 24 || result !== 16'd4 || result_ch !== 2'd3) begin
            n_errors++;
            $display("FAIL cont_third: got seen=%b n=%0d res=%0d ch=%0d want n=24 4 ch=3", seen, n, result, result_ch);
        end
        // Dropping mode_cont mid-GATE lets the running window finish, then IDLE.
        n = 0;
        wait_vld(1'b0, 10, n, seen);
        mode_cont = 1'b0;
        wait_vld(1'b0, 60, n, seen);
        n_checks++;
        if (!seen || n != 24 || result !== 16'd4) begin
            n_errors++; $display("FAIL cont_stop_last: got seen=%b n=%0d res=%0d want n=24 4", seen, n, result);
        end
        n = 0;
        wait_vld(1'b0, 40, n, seen);
        n_checks++;
        if (seen || busy !== 1'b0) begin
            n_errors++; $display("FAIL cont_stop_idle: got seen=%b busy=%b want 0 0", seen, busy);
        end
    endtask

    task automatic test_start_ignored();
        int n; bit seen;
        ch_sel = 2'd2; gate_len = 16'd20;
        start = 1'b1; n = 0;
        wait_vld(1'b0, 12, n, seen);
        start = 1'b1; gate_len = 16'd40; ch_sel = 2'd1;
        wait_vld(1'b0, 60, n, seen);
        n_checks++;
        if (!seen || n != 24 || result !== 16'd5 || result_ch !== 2'd2) begin
            n_errors++;
            $display("FAIL busy_start: got seen=%b n=%0d res=%0d ch=%0d want n=24 5 ch=2", seen, n, result, result_ch);
        end
        n = 0;
        wait_vld(1'b0, 60, n, seen);
        n_checks++;
        if (seen || busy !== 1'b0) begin
            n_errors++; $display("FAIL busy_start_idle: got seen=%b busy=%b want 0 0", seen, busy);
        end
    endtask

    task automatic test_ena_abort();
        int n; bit seen;
        ch_sel = 2'd1; gate_len = 16'd100;
        start = 1'b1; n = 0;
        wait_vld(1'b0, 50, n, seen);
        ena = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++; $display("FAIL ena_abort_busy: got %b want 0", busy);
        end
        n = 0;
        wait_vld(1'b0, 120, n, seen);
        n_checks++;
        if (seen || result !== 16'd5 || result_ch !== 2'd2) begin
            n_errors++;
            $display("FAIL ena_abort_hold: got seen=%b res=%0d ch=%0d want 0 5 ch=2", seen, result, result_ch);
        end
        // start together with ena low must not launch a measurement.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++; $display("FAIL ena_low_start: got busy=%b want 0", busy);
        end
        ena = 1'b1;
        tick();
    endtask

    task automatic test_zero_gate();
        int n; bit seen;
        per[0] = 0; ch_sel = 2'd0; gate_len = 16'd0;
        start = 1'b1; n = 0;
        wait_vld(1'b0, 30, n, seen);
        n_checks++;
        if (!seen || n != 5) begin
            n_errors++; $display("FAIL zero_gate_latency: got seen=%b n=%0d want n=5", seen, n);
        end
        n_checks++;
        if (result !== 16'd0 || result_ch !== 2'd0 || result_ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_gate_result: got %0d ch=%0d ovf=%b want 0 0 0", result, result_ch, result_ovf);
        end
        tick();
    endtask

    task automatic test_async_reset();
        int n; bit seen;
        ch_sel = 2'd1; gate_len = 16'd100;
        start = 1'b1; n = 0;
        wait_vld(1'b0, 104, n, seen);
        n_checks++;
        if (!seen || result !== 16'd10) begin
            n_errors++; $display("FAIL areset_pre: got seen=%b res=%0d want 1 10", seen, result);
        end
        start = 1'b1; n = 0;
        wait_vld(1'b0, 50, n, seen);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, result, result_ch, result_ovf, result_vld} !== 21'd0) begin
            n_errors++;
            $display("FAIL areset_outputs: got busy=%b res=%0d ch=%0d ovf=%b vld=%b want all 0",
                     busy, result, result_ch, result_ovf, result_vld);
        end
        tick();
        rst_n = 1'b1;
        n = 0;
        wait_vld(1'b0, 120, n, seen);
        n_checks++;
        if (seen || busy !== 1'b0) begin
            n_errors++; $display("FAIL areset_idle: got seen=%b busy=%b want 0 0", seen, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_saturate();
        test_continuous();
        test_start_ignored();
        test_ena_abort();
        test_zero_gate();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
